// File: rtl/frame_buf_ctrl_if.sv
// Bundle of camera, reader and frame-RAM signals around frame_buf_ctrl.
// slave is the controller's view; master is the surrounding system's view.
interface frame_buf_ctrl_if #(
  parameter int unsigned XW = 7,
  parameter int unsigned YW = 7,
  parameter int unsigned DW = 24
);
  logic          cam_valid;
  logic [DW-1:0] cam_data;
  logic          cam_sof;
  logic          cam_ready;
  logic          rd_req;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [XW-1:0] ram_x;
  logic [YW-1:0] ram_y;
  logic [DW-1:0] ram_din;
  logic          ram_write;
  logic [DW-1:0] ram_dout;
  logic          frame_done;

  modport slave (
    input  cam_valid, cam_data, cam_sof, rd_req, rd_x, rd_y, ram_dout,
    output cam_ready, rd_gnt, rd_valid, rd_data, ram_x, ram_y, ram_din, ram_write, frame_done
  );

  modport master (
    output cam_valid, cam_data, cam_sof, rd_req, rd_x, rd_y, ram_dout,
    input  cam_ready, rd_gnt, rd_valid, rd_data, ram_x, ram_y, ram_din, ram_write, frame_done
  );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Frame buffer RAM sequencer: raster-addresses camera pixels into a 2-deep write
// FIFO and round-robins the single RAM port between that FIFO and a random reader.
module frame_buf_ctrl #(
  parameter int unsigned WIDTH  = 101,
  parameter int unsigned HEIGHT = 101,
  parameter int unsigned XW     = 7,
  parameter int unsigned YW     = 7,
  parameter int unsigned DW     = 24
) (
  input logic              clk,
  input logic              reset,
  frame_buf_ctrl_if.slave  bus
);

  localparam logic [XW-1:0] XLast = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(HEIGHT - 1);

  logic [XW-1:0] fx_q    [2];
  logic [YW-1:0] fy_q    [2];
  logic [DW-1:0] fd_q    [2];
  logic          flast_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic [XW-1:0] wx_q;
  logic [YW-1:0] wy_q;
  logic          last_r_q;    // 1: reader was served most recently
  logic          rd_valid_q;
  logic          rd_oor_q;

  logic          push, pop, w_req, r_req, w_gnt, r_gnt, rd_oor, alast;
  logic [XW-1:0] ax, nx;
  logic [YW-1:0] ay, ny;

  always_comb begin
    bus.cam_ready = ~reset & (count_q != 2'd2);
    push          = bus.cam_valid & bus.cam_ready;

    ax    = bus.cam_sof ? '0 : wx_q;
    ay    = bus.cam_sof ? '0 : wy_q;
    alast = (ax == XLast) && (ay == YLast);
    if (ax == XLast) begin
      nx = '0;
      ny = (ay == YLast) ? '0 : ay + YW'(1);
    end else begin
      nx = ax + XW'(1);
      ny = ay;
    end

    // Nothing is granted in a reset cycle, so a read there is never served.
    w_req = ~reset & (count_q != 2'd0);
    r_req = ~reset & bus.rd_req;
    if (w_req && r_req) begin
      w_gnt = last_r_q;
      r_gnt = ~last_r_q;
    end else begin
      w_gnt = w_req;
      r_gnt = r_req;
    end
    pop    = w_gnt;
    rd_oor = (32'(bus.rd_x) >= WIDTH) || (32'(bus.rd_y) >= HEIGHT);

    bus.ram_write  = w_gnt;
    bus.rd_gnt     = r_gnt;
    bus.frame_done = w_gnt & flast_q[rd_ptr_q];
    bus.ram_din    = w_gnt ? fd_q[rd_ptr_q] : '0;
    if (w_gnt) begin
      bus.ram_x = fx_q[rd_ptr_q];
      bus.ram_y = fy_q[rd_ptr_q];
    end else if (r_gnt) begin
      bus.ram_x = bus.rd_x;
      bus.ram_y = bus.rd_y;
    end else begin
      bus.ram_x = '0;
      bus.ram_y = '0;
    end

    bus.rd_valid = rd_valid_q & ~reset;
    bus.rd_data  = (bus.rd_valid && !rd_oor_q) ? bus.ram_dout : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      wx_q       <= '0;
      wy_q       <= '0;
      last_r_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      if (push) begin
        fx_q[wr_ptr_q]    <= ax;
        fy_q[wr_ptr_q]    <= ay;
        fd_q[wr_ptr_q]    <= bus.cam_data;
        flast_q[wr_ptr_q] <= alast;
        wr_ptr_q          <= ~wr_ptr_q;
        wx_q              <= nx;
        wy_q              <= ny;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
      if (w_gnt || r_gnt) last_r_q <= r_gnt;
      rd_valid_q <= r_gnt;
      rd_oor_q   <= r_gnt & rd_oor;
    end
  end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Scoreboard bench for frame_buf_ctrl: drivers queue expected RAM writes and read
// data, a negedge monitor pops and compares whenever the DUT presents them.
module tb_frame_buf_ctrl;
  localparam int unsigned W  = 101;
  localparam int unsigned H  = 101;
  localparam int unsigned XW = 7;
  localparam int unsigned YW = 8;
  localparam int unsigned DW = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_buf_ctrl_if #(.XW(XW), .YW(YW), .DW(DW)) bus ();

  frame_buf_ctrl #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
    logic          last;
  } wexp_t;

  wexp_t         exp_wq[$];
  logic [DW-1:0] exp_rq[$];
  bit            gnt_log[$];
  int            n_vec = 0, n_bad = 0, done_cnt = 0;
  bit            sb_en = 0, log_en = 0, saw_busy = 0, gnt_prev = 0;
  int            ex = 0, ey = 0;
  wexp_t         me;
  logic [DW-1:0] mr;
  logic [DW-1:0] mem [0:32767];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Registered single-port RAM.
  always @(posedge clk) begin
    if (bus.ram_write) mem[{bus.ram_y, bus.ram_x}] <= bus.ram_din;
    bus.ram_dout <= mem[{bus.ram_y, bus.ram_x}];
  end

  always @(negedge clk) begin
    if (sb_en) begin
      if (bus.ram_write) begin
        check("write_expected", 32'(exp_wq.size() != 0), 1);
        if (exp_wq.size() != 0) begin
          me = exp_wq.pop_front();
          check("wr_x", 32'(bus.ram_x), 32'(me.x));
          check("wr_y", 32'(bus.ram_y), 32'(me.y));
          check("wr_din", 32'(bus.ram_din), 32'(me.d));
          check("wr_frame_done", 32'(bus.frame_done), 32'(me.last));
        end
      end else if (bus.frame_done) begin
        check("frame_done_without_write", 32'(bus.frame_done), 0);
      end
      if (bus.rd_valid) begin
        check("rd_expected", 32'(exp_rq.size() != 0), 1);
        if (exp_rq.size() != 0) begin
          mr = exp_rq.pop_front();
          check("rd_data", 32'(bus.rd_data), 32'(mr));
        end
      end
      if (bus.rd_valid || gnt_prev) check("rd_latency", 32'(bus.rd_valid), 32'(gnt_prev));
      if (bus.rd_gnt) check("rd_gnt_no_write", 32'(bus.ram_write), 0);
      if (log_en && (bus.rd_gnt || bus.ram_write)) gnt_log.push_back(bus.rd_gnt);
      if (log_en && !reset && !bus.cam_ready) saw_busy = 1;
    end
    if (bus.frame_done) done_cnt++;
    gnt_prev = bus.rd_gnt;
  end

  task automatic send_pixel(input logic [DW-1:0] d, input bit sof);
    bit    acc = 0;
    int    ax, ay;
    wexp_t e;
    bus.cam_valid = 1'b1;
    bus.cam_data  = d;
    bus.cam_sof   = sof;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      if (bus.cam_ready) begin
        acc    = 1;
        ax     = sof ? 0 : ex;
        ay     = sof ? 0 : ey;
        e.x    = XW'(ax);
        e.y    = YW'(ay);
        e.d    = d;
        e.last = (ax == W - 1) && (ay == H - 1);
        exp_wq.push_back(e);
        if (ax == W - 1) begin
          ex = 0;
          ey = (ay == H - 1) ? 0 : ay + 1;
        end else begin
          ex = ax + 1;
          ey = ay;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.cam_valid = 1'b0;
    bus.cam_sof   = 1'b0;
    if (!acc) check("cam_accept_timeout", 0, 1);
  endtask

  task automatic do_read(input int x, input int y, input logic [DW-1:0] expd);
    bit g = 0;
    bus.rd_req = 1'b1;
    bus.rd_x   = XW'(x);
    bus.rd_y   = YW'(y);
    for (int i = 0; i < 64 && !g; i++) begin
      @(negedge clk);
      if (bus.rd_gnt) begin
        g = 1;
        exp_rq.push_back(expd);
        check("rd_ram_x", 32'(bus.ram_x), 32'(x));
        check("rd_ram_y", 32'(bus.ram_y), 32'(y));
        check("rd_ram_write", 32'(bus.ram_write), 0);
      end
      @(posedge clk);
      #1;
    end
    bus.rd_req = 1'b0;
    if (!g) check("rd_grant_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_wq.size() + exp_rq.size()) != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("drain_pending", 32'(exp_wq.size() + exp_rq.size()), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_wq.delete();
    exp_rq.delete();
    ex    = 0;
    ey    = 0;
    reset = 1'b0;
  endtask

  initial begin
    int  d0;
    bit  found, seen_w;
    for (int i = 0; i < 32768; i++) mem[i] = 24'h5A5A5A;
    bus.cam_valid = 1'b0;
    bus.cam_data  = '0;
    bus.cam_sof   = 1'b0;
    bus.rd_req    = 1'b0;
    bus.rd_x      = '0;
    bus.rd_y      = '0;

    @(negedge clk);
    check("rst_cam_ready", 32'(bus.cam_ready), 0);
    check("rst_rd_gnt", 32'(bus.rd_gnt), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_ram_write", 32'(bus.ram_write), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_en = 1;
    @(negedge clk);
    check("post_rst_cam_ready", 32'(bus.cam_ready), 1);
    check("post_rst_rd_data", 32'(bus.rd_data), 0);
    check("idle_ram_x", 32'(bus.ram_x), 0);
    check("idle_ram_din", 32'(bus.ram_din), 0);
    @(posedge clk);
    #1;

    // Full frame, data = raster index.
    for (int i = 0; i < int'(W * H); i++) send_pixel(DW'(i), i == 0);
    drain();
    check("frame_done_count", 32'(done_cnt), 1);

    // Counters wrapped: next pixel lands at (0,0); index 308 is (5,3).
    for (int i = 0; i <= 308; i++) send_pixel((i == 308) ? 24'hABCDEF : DW'(24'h200000 + i), 0);
    drain();
    do_read(5, 3, 24'hABCDEF);
    drain();

    // Out-of-range reads return zero.
    do_read(101, 0, '0);
    do_read(0, 200, '0);
    drain();

    // Mid-frame sof: pixel 50 restarts at (0,0), pixel 51 at (1,0).
    d0 = done_cnt;
    for (int i = 0; i < 52; i++) send_pixel(DW'(24'h300000 + i), (i == 0) || (i == 50));
    drain();
    check("sof_no_frame_done", 32'(done_cnt), 32'(d0));
    do_read(0, 0, 24'h300032);
    do_read(1, 0, 24'h300033);
    drain();

    // Camera and reader contending from reset.
    do_reset();
    gnt_log.delete();
    saw_busy = 0;
    log_en   = 1;
    fork
      begin
        for (int i = 0; i < 12; i++) send_pixel(DW'(24'h100000 + i), i == 0);
      end
      begin
        for (int i = 0; i < 8; i++) do_read(i, 50, DW'(50 * 101 + i));
      end
    join
    drain();
    log_en = 0;
    if (gnt_log.size() >= 16) begin
      for (int i = 0; i < 16; i++) check("gnt_order", 32'(gnt_log[i]), (i % 2 == 0) ? 1 : 0);
    end else begin
      check("gnt_log_len", 32'(gnt_log.size()), 16);
    end
    check("cam_ready_dropped", 32'(saw_busy), 1);

    // Reset with two queued pixels and a read granted on the previous edge.
    sb_en         = 0;
    bus.cam_valid = 1'b1;
    bus.cam_sof   = 1'b0;
    bus.cam_data  = 24'h777777;
    bus.rd_req    = 1'b1;
    bus.rd_x      = '0;
    bus.rd_y      = YW'(50);
    found  = 0;
    seen_w = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (seen_w && bus.rd_gnt && bus.cam_ready) found = 1;
      if (bus.ram_write) seen_w = 1;
    end
    check("rst_scenario_found", 32'(found), 1);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.cam_valid = 1'b0;
    bus.rd_req    = 1'b0;
    @(negedge clk);
    check("midrst_ram_write", 32'(bus.ram_write), 0);
    check("midrst_rd_valid", 32'(bus.rd_valid), 0);
    check("midrst_cam_ready", 32'(bus.cam_ready), 0);
    check("midrst_frame_done", 32'(bus.frame_done), 0);
    exp_wq.delete();
    exp_rq.delete();
    ex = 0;
    ey = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb_en = 1;
    @(negedge clk);
    check("after_rst_cam_ready", 32'(bus.cam_ready), 1);
    check("after_rst_rd_valid", 32'(bus.rd_valid), 0);
    check("after_rst_rd_data", 32'(bus.rd_data), 0);
    check("after_rst_ram_write", 32'(bus.ram_write), 0);
    check("after_rst_ram_y", 32'(bus.ram_y), 0);
    repeat (5) @(posedge clk);
    #1;
    send_pixel(24'h123456, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
